efc_transition_scheduler: RTL and testbench
===========================================

# efc_transition_scheduler

Cycle-level scheduler that fires the shared transition inputs (t0..t6 style) of a set of synchronised Mealy FSMs. It grants at most one transition per firing slot, and only among requested transitions that the FSMs' place/state-sync outputs currently enable. Conflicting (free-choice) requests are resolved round-robin. After each fire it holds off for a settle window so the FSMs' synchronisation outputs can update. It sits between the environment/testbench request logic and the FSM wrapper's transition inputs.

## Interface
Parameters:
- N_T, 7: number of transitions (width of req/en/fire).
- SETTLE_CYC, 1: cycles held in SETTLE after each fire; legal range 1..15.
- STALL_LIMIT, 15: consecutive blocked IDLE cycles before stall asserts; legal range 1..255.
- CNT_W, 16: width of fire_cnt.

Ports:
- clk  in  1  the single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- req  in  N_T  level request per transition; held by the requester until it sees its fire bit.
- en  in  N_T  enable mask, combinationally derived from the FSMs' place outputs; bit i=1 means transition i is fireable.
- fire  out  N_T  registered, one-hot or zero; drives the transition inputs.
- fire_idx  out  $clog2(N_T)  index of the transition fired in the current FIRE cycle; holds its last value otherwise.
- busy  out  1  high in FIRE and SETTLE.
- stall  out  1  requests pending but none enabled for STALL_LIMIT cycles.
- fire_cnt  out  CNT_W  total fires since reset; wraps.

## Operation
- State machine states:
  - IDLE: evaluate cand = req & en.
    - cand != 0: choose the first set bit at or above ptr, cyclically. Go to FIRE, setting fire = onehot(sel) and fire_idx = sel.
    - cand == 0: remain in IDLE with fire = 0.
  - FIRE: lasts exactly one cycle. Then:
    - fire = 0 on the next edge;
    - ptr = (sel+1) mod N_T;
    - fire_cnt increments by 1 (mod 2^CNT_W);
    - settle counter loads SETTLE_CYC-1;
    - state goes to SETTLE.
  - SETTLE: counter decrements each cycle. When it reads 0, go to IDLE on the next edge. req and en are ignored in this state.
- Stall counter (8-bit, saturating):
  - Increments on each IDLE cycle with req != 0 and cand == 0.
  - Clears when cand != 0, when req == 0, or whenever the FSM is not in IDLE.
  - stall = (count >= STALL_LIMIT). stall is informational only; it never blocks firing.
- ptr is a free-running round-robin base. Only firing updates it.
- Reset values: state IDLE, fire 0, fire_idx 0, ptr 0, busy 0, stall 0, stall counter 0, fire_cnt 0.

## Timing
- Latency: a candidate present in IDLE at edge k produces a fire pulse in cycle k+1 (registered, one cycle wide).
- Minimum fire-to-fire spacing: 2+SETTLE_CYC cycles. With SETTLE_CYC=1 the pattern is FIRE, SETTLE, IDLE, FIRE.
- Requester handshake: it may deassert req in the cycle after its fire bit is seen. A req still high when the scheduler returns to IDLE is eligible again.
- A req bit dropping during FIRE or SETTLE has no effect on the fire already in progress.
- Simultaneous candidates: exactly one is fired. The others wait at least one full slot. Under continuous contention, round-robin guarantees each waits at most N_T-1 slots.
- en changing during SETTLE is the expected case; it is first sampled in IDLE.
- Reset asserted in any state takes effect at that edge. Example: reset during FIRE forces fire = 0 from the next cycle, and fire_cnt is cleared.
- fire_cnt wrap: the value 2^CNT_W-1 goes to 0 on the next fire.

## Structure
- Package efc_sched_pkg contains:
  - the state enum {IDLE, FIRE, SETTLE};
  - the default N_T;
  - the stall counter width constant (8).
- Sub-module rr_pick: a combinational round-robin priority picker. Inputs are cand and ptr; outputs are the any flag, sel index and one-hot grant. It is reusable by other FSM-array wrappers.
- Top level holds the state register, settle counter, stall counter, ptr and fire_cnt.

## Test plan
- Single request: after reset, req=0000100, en=1111111 → fire=0000100 for one cycle, 1 cycle after sampling; fire_idx=2; fire_cnt=1; busy high for 2 cycles (SETTLE_CYC=1).
- Conflict fairness: req=0000011 held, en=0000011 → fires alternate t0, t1, t0, t1, spaced 3 cycles apart; fire_cnt=4 after 4 slots.
- Disabled request: req=0001000, en=0000000 for 20 cycles → fire stays 0; stall rises after 15 blocked cycles. Setting en=0001000 → stall clears next cycle; t3 fires.
- Settle masking: SETTLE_CYC=3, req=1111111, en=1111111 → consecutive fires exactly 5 cycles apart, never two fire bits set together.
- Reset mid-operation: assert reset (low) during FIRE of t6 → fire=0, fire_cnt=0, ptr=0, state IDLE next cycle. First fire after release comes from index 0 when all bits are requested.
- Counter wrap: CNT_W=4, 17 fires → fire_cnt=1.

Source files
------------

// File: rtl/efc_sched_pkg.sv
// Shared types and constants for the EFC transition scheduler.
// Reused by the scheduler top, its bus interface and sibling wrappers.
package efc_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      SETTLE
   } state_t;

   localparam int N_T_DEF = 7;
   localparam int STALL_W = 8;

endpackage

// File: rtl/efc_transition_scheduler_if.sv
// Request/enable in, fire/status out, between requester and scheduler.
// master = request side, slave = scheduler side.
interface efc_transition_scheduler_if
   import efc_sched_pkg::*;
#(
   parameter int N_T   = N_T_DEF,
   parameter int CNT_W = 16
);

   localparam int IW = (N_T > 1) ? $clog2(N_T) : 1;

   logic [N_T-1:0]   req;
   logic [N_T-1:0]   en;
   logic [N_T-1:0]   fire;
   logic [IW-1:0]    fire_idx;
   logic             busy;
   logic             stall;
   logic [CNT_W-1:0] fire_cnt;

   modport master (
      output req, en,
      input  fire, fire_idx, busy, stall, fire_cnt
   );

   modport slave (
      input  req, en,
      output fire, fire_idx, busy, stall, fire_cnt
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of cand at or above
// ptr, wrapping cyclically. grant is one-hot or zero.
module rr_pick #(
   parameter int N  = 7,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  cand,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] sel,
   output logic [N-1:0]  grant
);

   logic [IW-1:0] k;

   always_comb begin
      any   = 1'b0;
      sel   = '0;
      grant = '0;
      k     = '0;
      for (int j = 0; j < N; j++) begin
         k = IW'((int'(ptr) + j) % N);
         if (!any && cand[k]) begin
            any      = 1'b1;
            sel      = k;
            grant[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/efc_transition_scheduler.sv
// Fires at most one enabled, requested transition per slot, round-robin,
// then holds off for a settle window so FSM sync outputs can update.
module efc_transition_scheduler
   import efc_sched_pkg::*;
#(
   parameter int N_T         = N_T_DEF,
   parameter int SETTLE_CYC  = 1,
   parameter int STALL_LIMIT = 15,
   parameter int CNT_W       = 16
) (
   input logic clk,
   input logic reset,
   efc_transition_scheduler_if.slave bus
);

   localparam int IW = (N_T > 1) ? $clog2(N_T) : 1;
   localparam int SW = 4;

   state_t             state_q, state_d;
   logic [N_T-1:0]     fire_q, fire_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]      settle_q, settle_d;
   logic [STALL_W-1:0] stall_q, stall_d;

   logic [N_T-1:0] cand;
   logic [N_T-1:0] grant;
   logic [IW-1:0]  sel;
   logic           any;

   assign cand = bus.req & bus.en;

   rr_pick #(
      .N  (N_T),
      .IW (IW)
   ) u_pick (
      .cand  (cand),
      .ptr   (ptr_q),
      .any   (any),
      .sel   (sel),
      .grant (grant)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         fire_q   <= '0;
         idx_q    <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         settle_q <= '0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         fire_q   <= fire_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         stall_q  <= stall_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fire_d   = '0;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      stall_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (any) begin
               state_d = FIRE;
               fire_d  = grant;
               idx_d   = sel;
            end else if (|bus.req) begin
               // saturate so a long block cannot wrap stall back low
               stall_d = (stall_q == '1) ? stall_q : stall_q + 1'b1;
            end
         end
         FIRE: begin
            state_d  = SETTLE;
            ptr_d    = (idx_q == IW'(N_T - 1)) ? '0 : idx_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            settle_d = SW'(SETTLE_CYC - 1);
         end
         SETTLE: begin
            if (settle_q == '0) state_d = IDLE;
            else settle_d = settle_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.fire     = fire_q;
   assign bus.fire_idx = idx_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.stall    = (stall_q >= STALL_W'(STALL_LIMIT));
   assign bus.fire_cnt = cnt_q;

endmodule

// File: tb/tb_efc_transition_scheduler.sv
// Directed vector table for the default scheduler plus a hand-written
// settle/wrap sequence on a SETTLE_CYC=3, CNT_W=4 instance.
module tb_efc_transition_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   efc_transition_scheduler_if #(.N_T(7), .CNT_W(16)) bus_a ();
   efc_transition_scheduler_if #(.N_T(7), .CNT_W(4))  bus_b ();

   efc_transition_scheduler #(
      .N_T(7), .SETTLE_CYC(1), .STALL_LIMIT(15), .CNT_W(16)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   efc_transition_scheduler #(
      .N_T(7), .SETTLE_CYC(3), .STALL_LIMIT(15), .CNT_W(4)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   typedef struct {
      logic        rst;
      logic [6:0]  req;
      logic [6:0]  en;
      logic [6:0]  fire;
      logic [2:0]  idx;
      logic        busy;
      logic        stall;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic void add(
      input logic rst, input logic [6:0] req, input logic [6:0] en,
      input logic [6:0] fire, input logic [2:0] idx, input logic busy,
      input logic stall, input logic [15:0] cnt
   );
      vec_t v;
      v.rst = rst; v.req = req; v.en = en;
      v.fire = fire; v.idx = idx; v.busy = busy;
      v.stall = stall; v.cnt = cnt;
      tbl.push_back(v);
   endfunction

   initial begin
      int   last_fire;
      int   n_fire;
      vec_t v;

      bus_a.req = '0; bus_a.en = '0;
      bus_b.req = '0; bus_b.en = '0;

      // reset
      add(0, 7'h00, 7'h00, 7'h00, 0, 0, 0, 0);
      // single request t2
      add(1, 7'h04, 7'h7F, 7'h04, 2, 1, 0, 0);
      add(1, 7'h04, 7'h7F, 7'h00, 2, 1, 0, 1);
      add(1, 7'h00, 7'h7F, 7'h00, 2, 0, 0, 1);
      // conflict t0/t1, ptr starts at 3
      add(1, 7'h03, 7'h03, 7'h01, 0, 1, 0, 1);
      add(1, 7'h03, 7'h03, 7'h00, 0, 1, 0, 2);
      add(1, 7'h03, 7'h03, 7'h00, 0, 0, 0, 2);
      add(1, 7'h03, 7'h03, 7'h02, 1, 1, 0, 2);
      add(1, 7'h03, 7'h03, 7'h00, 1, 1, 0, 3);
      add(1, 7'h03, 7'h03, 7'h00, 1, 0, 0, 3);
      add(1, 7'h03, 7'h03, 7'h01, 0, 1, 0, 3);
      add(1, 7'h03, 7'h03, 7'h00, 0, 1, 0, 4);
      add(1, 7'h03, 7'h03, 7'h00, 0, 0, 0, 4);
      add(1, 7'h03, 7'h03, 7'h02, 1, 1, 0, 4);
      add(1, 7'h03, 7'h03, 7'h00, 1, 1, 0, 5);
      add(1, 7'h03, 7'h03, 7'h00, 1, 0, 0, 5);
      add(1, 7'h00, 7'h00, 7'h00, 1, 0, 0, 5);
      // t3 requested but disabled for 20 cycles
      for (int i = 1; i <= 20; i++)
         add(1, 7'h08, 7'h00, 7'h00, 1, 0, (i >= 15), 5);
      add(1, 7'h08, 7'h08, 7'h08, 3, 1, 0, 5);
      add(1, 7'h08, 7'h08, 7'h00, 3, 1, 0, 6);
      add(1, 7'h00, 7'h00, 7'h00, 3, 0, 0, 6);
      // t6 fires, reset lands during its FIRE cycle
      add(1, 7'h40, 7'h7F, 7'h40, 6, 1, 0, 6);
      add(0, 7'h7F, 7'h7F, 7'h00, 0, 0, 0, 0);
      add(1, 7'h7F, 7'h7F, 7'h01, 0, 1, 0, 0);
      add(1, 7'h7F, 7'h7F, 7'h00, 0, 1, 0, 1);
      add(1, 7'h7F, 7'h7F, 7'h00, 0, 0, 0, 1);
      add(1, 7'h7F, 7'h7F, 7'h02, 1, 1, 0, 1);
      add(1, 7'h00, 7'h00, 7'h00, 1, 1, 0, 2);
      add(1, 7'h00, 7'h00, 7'h00, 1, 0, 0, 2);
      // req drops during FIRE: fire still completes and counts
      add(1, 7'h04, 7'h7F, 7'h04, 2, 1, 0, 2);
      add(1, 7'h00, 7'h7F, 7'h00, 2, 1, 0, 3);
      add(1, 7'h00, 7'h7F, 7'h00, 2, 0, 0, 3);

      foreach (tbl[i]) begin
         v = tbl[i];
         reset = v.rst;
         bus_a.req = v.req;
         bus_a.en = v.en;
         @(posedge clk);
         #1;
         n_vec++;
         if ({bus_a.fire, bus_a.fire_idx, bus_a.busy, bus_a.stall,
              bus_a.fire_cnt} !==
             {v.fire, v.idx, v.busy, v.stall, v.cnt}) begin
            n_err++;
            $display("FAIL vec%0d: got fire=%b idx=%0d busy=%b stall=%b cnt=%0d, want fire=%b idx=%0d busy=%b stall=%b cnt=%0d",
               i, bus_a.fire, bus_a.fire_idx, bus_a.busy, bus_a.stall,
               bus_a.fire_cnt, v.fire, v.idx, v.busy, v.stall, v.cnt);
         end
      end

      // settle masking and counter wrap on dut_b (idle since reset)
      bus_a.req = '0;
      bus_a.en = '0;
      bus_b.req = 7'h7F;
      bus_b.en = 7'h7F;
      last_fire = -1;
      n_fire = 0;
      for (int c = 1; c <= 85; c++) begin
         @(posedge clk);
         #1;
         if ($countones(bus_b.fire) > 1) begin
            n_vec++;
            n_err++;
            $display("FAIL onehot c%0d: got fire=%b, want at most one bit",
               c, bus_b.fire);
         end else if (bus_b.fire != '0) begin
            n_vec++;
            if (bus_b.fire_idx !== 3'(n_fire % 7) ||
                bus_b.fire !== 7'(1 << (n_fire % 7)) ||
                bus_b.fire_cnt !== 4'(n_fire % 16) ||
                (last_fire >= 0 && c - last_fire != 5) ||
                (last_fire < 0 && c != 1)) begin
               n_err++;
               $display("FAIL rr_fire%0d c%0d: got idx=%0d fire=%b cnt=%0d gap=%0d, want idx=%0d cnt=%0d gap=5",
                  n_fire, c, bus_b.fire_idx, bus_b.fire, bus_b.fire_cnt,
                  c - last_fire, n_fire % 7, n_fire % 16);
            end
            last_fire = c;
            n_fire++;
         end
      end
      bus_b.req = '0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (n_fire != 17 || bus_b.fire_cnt !== 4'd1 || bus_b.busy !== 1'b0) begin
         n_err++;
         $display("FAIL wrap: got fires=%0d cnt=%0d busy=%b, want fires=17 cnt=1 busy=0",
            n_fire, bus_b.fire_cnt, bus_b.busy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
